writeback_stage_pipe: RTL
=========================

Name: writeback_stage_pipe

Overview:
Parametrised successor to the RV32I write-back mux. Adds a registered write-back stage with a valid/ready handshake from the memory stage. Also performs load byte/halfword extraction with sign/zero extension, selects among four result sources, suppresses writes to x0, and flags misaligned loads. Sits between the memory stage and the register file; its output register also drives the forwarding unit.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register-file address width
RSEL_W, 2, result-select width (2^RSEL_W sources; sources 0-3 defined, others read as 0)
CNT_W, 64, retire-counter width (used only with WB_INSTRET_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  memory stage presents an instruction
in_ready  out  1  stage can accept this cycle
ResultSrcM  in  RSEL_W  00 ALU, 01 load, 10 PC+4, 11 CSR/imm
ALU_ResultM  in  XLEN  ALU result; bits [1:0] give the load byte offset
ReadDataM  in  XLEN  raw aligned memory word
PCPlus4M  in  XLEN  PC+4
AuxDataM  in  XLEN  CSR/immediate data
funct3M  in  3  load type
RdM  in  REG_AW  destination register
RegWriteM  in  1  instruction writes rd
stall_w  in  1  freeze output register
rf_we  out  1  register-file write enable
rf_waddr  out  REG_AW  write address
rf_wdata  out  XLEN  write data (ResultW)
misalign_err  out  1  one-cycle flag for a misaligned load
misalign_addr  out  XLEN  faulting address
instret  out  CNT_W  retired-instruction count (only with WB_INSTRET_EN)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: out_valid=0, rf_we=0, rf_waddr=0, rf_wdata=0, misalign_err=0, misalign_addr=0, instret=0. Reset during a stall discards the held instruction.
- Ready: in_ready = ~stall_w | ~out_valid.
- Accept: an instruction is accepted when in_valid & in_ready. Latency is exactly 1 cycle from accept to rf_we/rf_waddr/rf_wdata.
- Idle: if no instruction is accepted and there is no stall, out_valid<=0 next cycle.
- Stall: while stall_w & out_valid, all outputs hold. rf_we stays asserted with identical data; repeated writes are idempotent by design.
- Write enable: rf_we = out_valid & registered RegWrite & (rf_waddr != 0) & ~misaligned. An x0 target never asserts rf_we.
- Result select, source 00: ALU_ResultM.
- Result select, source 01: load extraction using off = ALU_ResultM[1:0]:
  - LB(000): sign-extend byte[off]; LBU(100): zero-extend byte[off].
  - LH(001): sign-extend half[off[1]]; LHU(101): zero-extend half[off[1]].
  - LW(010): full word. Other funct3 values are treated as LW.
- Result select, sources 10 and 11: PCPlus4M and AuxDataM respectively; RSEL_W>2 values beyond 11 read as 0.
- Misalignment: a source-01 load is misaligned if it is LH/LHU with off[0]=1, or LW with off!=0.
  - On accept of a misaligned load: misalign_err=1 for exactly one cycle (not held during a stall), misalign_addr=ALU_ResultM, and the write is suppressed.
- Simultaneous stall_w & in_valid with out_valid=1: in_ready=0 and nothing is accepted; the upstream stage must hold its inputs.

Optional Feature:
WB_INSTRET_EN: when defined, instret increments by 1 per accepted instruction, including x0 writes and misaligned loads; it wraps at 2^CNT_W and is never incremented while stalled. When undefined, the instret port is tied to 0 and the counter logic is absent.

Decomposition:
- Package wb_pkg: result-source encodings (RS_ALU, RS_LOAD, RS_PC4, RS_AUX), load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU), XLEN default.
- Sub-module load_align: combinational byte/half extraction, extension and misalignment detect. The top level holds the handshake, output register and counter.

Test Plan:
- Basic ALU: RegWriteM=1, RdM=5, ResultSrcM=00, ALU_ResultM=0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; instret=1 with WB_INSTRET_EN.
- Loads on ReadDataM=0x80FF7F01: LB off=2 -> 0xFFFFFFFF; LBU off=3 -> 0x00000080; LH off=2 -> 0xFFFF80FF; LHU off=0 -> 0x00007F01.
- Misaligned: LW with ALU_ResultM=0x1002 -> rf_we=0, misalign_err=1 for one cycle, misalign_addr=0x1002.
- x0 suppression: RdM=0, RegWriteM=1, ALU_ResultM=0xDEAD -> rf_we=0; instret still increments.
- Stall: stall_w=1 for 3 cycles with in_valid=1 -> in_ready=0, outputs held, second instruction accepted on the first cycle after stall_w falls.
- Reset mid-stall: rst=1 while holding a valid write -> next cycle rf_we=0, instret=0, in_ready=1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: result-source selects,
// load funct3 values and the default datapath width.
package wb_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        RS_ALU  = 2'b00,
        RS_LOAD = 2'b01,
        RS_PC4  = 2'b10,
        RS_AUX  = 2'b11
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: picks the byte/half addressed by the low
// address bits out of the aligned memory word, sign/zero-extends it and
// flags misaligned half/word accesses. Unknown funct3 values behave as LW.
module load_align
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ldata,
    output logic            misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select from the aligned word
    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extension and alignment check per load type
    always_comb begin
        ldata      = rdata;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  ldata = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: ldata = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                ldata      = {{(XLEN-16){half_sel[15]}}, half_sel};
                misaligned = offset[0];
            end
            F3_LHU: begin
                ldata      = {{(XLEN-16){1'b0}}, half_sel};
                misaligned = offset[0];
            end
            F3_LW: begin
                ldata      = rdata;
                misaligned = |offset;
            end
            default: begin
                ldata      = rdata;
                misaligned = |offset;
            end
        endcase
    end

endmodule

// File: rtl/writeback_stage_pipe.sv
// Registered write-back stage with valid/ready handshake from the memory
// stage. Selects among ALU / load / PC+4 / aux results, suppresses x0 and
// misaligned-load writes, and reports misaligned loads for one cycle.
// Optional macro WB_INSTRET_EN adds a retired-instruction counter.
module writeback_stage_pipe
    import wb_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned RSEL_W = 2,
    parameter int unsigned CNT_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RSEL_W-1:0] ResultSrcM,
    input  logic [XLEN-1:0]   ALU_ResultM,
    input  logic [XLEN-1:0]   ReadDataM,
    input  logic [XLEN-1:0]   PCPlus4M,
    input  logic [XLEN-1:0]   AuxDataM,
    input  logic [2:0]        funct3M,
    input  logic [REG_AW-1:0] RdM,
    input  logic              RegWriteM,
    input  logic              stall_w,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              misalign_err,
    output logic [XLEN-1:0]   misalign_addr,
    output logic [CNT_W-1:0]  instret
);

    logic              out_valid_q,     out_valid_d;
    logic              regwrite_q,      regwrite_d;
    logic              mis_q,           mis_d;
    logic [REG_AW-1:0] waddr_q,         waddr_d;
    logic [XLEN-1:0]   wdata_q,         wdata_d;
    logic              misalign_err_q,  misalign_err_d;
    logic [XLEN-1:0]   misalign_addr_q, misalign_addr_d;

    logic              accept;
    logic              sel_ok;
    result_src_e       rsel;
    logic [XLEN-1:0]   load_data;
    logic              load_mis;
    logic              load_mis_sel;
    logic [XLEN-1:0]   result;

    // Select codes above the four defined sources read as zero
    generate
        if (RSEL_W > 2) begin : g_wide_sel
            assign sel_ok = ~|ResultSrcM[RSEL_W-1:2];
        end else begin : g_narrow_sel
            assign sel_ok = 1'b1;
        end
    endgenerate

    assign rsel = result_src_e'(ResultSrcM[1:0]);

    load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .funct3     (funct3M),
        .offset     (ALU_ResultM[1:0]),
        .rdata      (ReadDataM),
        .ldata      (load_data),
        .misaligned (load_mis)
    );

    assign load_mis_sel = sel_ok & (rsel == RS_LOAD) & load_mis;
    assign in_ready     = ~stall_w | ~out_valid_q;
    assign accept       = in_valid & in_ready;

    // Result source mux
    always_comb begin
        result = '0;
        if (sel_ok) begin
            case (rsel)
                RS_ALU:  result = ALU_ResultM;
                RS_LOAD: result = load_data;
                RS_PC4:  result = PCPlus4M;
                RS_AUX:  result = AuxDataM;
                default: result = '0;
            endcase
        end
    end

    // Output register next-state: load on accept, hold on stall, else drain
    always_comb begin
        out_valid_d     = out_valid_q;
        regwrite_d      = regwrite_q;
        mis_d           = mis_q;
        waddr_d         = waddr_q;
        wdata_d         = wdata_q;
        misalign_addr_d = misalign_addr_q;
        misalign_err_d  = 1'b0;
        if (accept) begin
            out_valid_d = 1'b1;
            regwrite_d  = RegWriteM;
            mis_d       = load_mis_sel;
            waddr_d     = RdM;
            wdata_d     = result;
            if (load_mis_sel) begin
                misalign_err_d  = 1'b1;
                misalign_addr_d = ALU_ResultM;
            end
        end else if (!(stall_w && out_valid_q)) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q     <= 1'b0;
            regwrite_q      <= 1'b0;
            mis_q           <= 1'b0;
            waddr_q         <= '0;
            wdata_q         <= '0;
            misalign_err_q  <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            out_valid_q     <= out_valid_d;
            regwrite_q      <= regwrite_d;
            mis_q           <= mis_d;
            waddr_q         <= waddr_d;
            wdata_q         <= wdata_d;
            misalign_err_q  <= misalign_err_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    assign rf_we         = out_valid_q & regwrite_q & (waddr_q != '0) & ~mis_q;
    assign rf_waddr      = waddr_q;
    assign rf_wdata      = wdata_q;
    assign misalign_err  = misalign_err_q;
    assign misalign_addr = misalign_addr_q;

`ifdef WB_INSTRET_EN
    logic [CNT_W-1:0] instret_q, instret_d;

    // Retire counter: one per accepted instruction, wraps naturally
    always_comb begin
        instret_d = instret_q;
        if (accept) begin
            instret_d = instret_q + 1'b1;
        end
    end

    // Retire counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule
